zipdbg_master: RTL
==================

# zipdbg_master

Debug-bus initiator that drives the two-address ZipCPU debug Wishbone slave port (address 0 = control/status, address 1 = register data) from a simple command/response interface. It sequences the mandatory control-write-then-data-access pair for CPU register reads and writes, and issues halt, go, step and reset commands. It sits between a host link (UART/JTAG bridge) and the debug slave port of the CPU wrapper.

## Interface
- TIMEOUT, 1023: maximum cycles waited for ack per bus phase. Active only with the timeout feature; counter width is `$clog2(TIMEOUT+1)`.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_cmd_stb  in  1  command valid; accepted when `!o_cmd_busy`
- i_cmd_op  in  3  0=RD_CTRL, 1=WR_CTRL, 2=RD_REG, 3=WR_REG, 4=HALT, 5=GO, 6=STEP, 7=RESET
- i_cmd_reg  in  5  CPU register index for RD_REG/WR_REG
- i_cmd_data  in  32  write data for WR_CTRL/WR_REG
- o_cmd_busy  out  1  high from the cycle after acceptance through the o_rsp_stb cycle
- o_rsp_stb  out  1  one-cycle response pulse
- o_rsp_data  out  32  read data; 0 for write-type ops
- o_rsp_err  out  1  valid with o_rsp_stb; timeout occurred
- o_dbg_cyc, o_dbg_stb, o_dbg_we  out  1  Wishbone master controls
- o_dbg_addr  out  1  0=control, 1=data
- o_dbg_data  out  32  write data
- i_dbg_ack, i_dbg_stall  in  1  slave handshake
- i_dbg_data  in  32  slave read data

## Operation
- States: IDLE, C_STB, C_WAIT, GAP, D_STB, D_WAIT, RESP.
- Control-word values: HALT=0x400, GO=0x000, STEP=0x100, RESET=0x440, RD_REG/WR_REG=0x400|reg. WR_CTRL sends i_cmd_data verbatim.
- Single-phase ops: HALT, GO, STEP, RESET and WR_CTRL write address 0. RD_CTRL reads address 0. Flow: IDLE→C_STB→C_WAIT→RESP.
- Two-phase ops (RD_REG, WR_REG): control write, then GAP, then D_STB→D_WAIT on address 1 (read or write i_cmd_data), then RESP.
- Command fields are latched on acceptance and held stable for the whole operation.
- *_STB states: cyc=1, stb=1. Advance to *_WAIT on the first cycle with `!i_dbg_stall`. Acks are ignored in *_STB.
- *_WAIT states: cyc=1, stb=0. The first i_dbg_ack completes the phase. Read data is captured on that ack.
- GAP: cyc=0 for exactly one cycle. An ack in GAP is a stale ack from the prior phase and is discarded. This is required because the slave registers an ack for every cycle cyc is high.
- RESP: o_rsp_stb=1 for one cycle, cyc=0, then return to IDLE. An ack seen in RESP or IDLE is ignored.
- i_cmd_stb while busy is dropped; no queueing.
- i_rst: next edge forces IDLE with all outputs 0. An in-flight operation is abandoned and produces no response. Reset is not delayed until ack.

## Timing
- Reset values: cyc, stb, we, addr, o_dbg_data, o_cmd_busy, o_rsp_stb, o_rsp_data, o_rsp_err all 0.
- Accept at edge of cycle 0; cyc/stb asserted in cycle 1.
- Single-phase, no stall, ack in cycle 2: o_rsp_stb in cycle 3.
- Two-phase, no stall, ack next cycle each phase: control ack in cycle 2, GAP in cycle 3, D_STB in cycle 4, ack in cycle 5, o_rsp_stb in cycle 6.
- Each stall cycle adds one cycle. Ack delay adds cycles one-for-one.
- Back-to-back: the next command may be accepted in the cycle after o_rsp_stb.

## Configuration
- ZIPDBG_TIMEOUT_EN defined:
  - Counter clears on entering each *_STB state and counts every cycle in *_STB/*_WAIT.
  - Reaching TIMEOUT drops cyc/stb and goes to RESP with o_rsp_err=1 and o_rsp_data=0. The remaining phase is skipped.
- Undefined: no counter; o_rsp_err is constant 0; the master waits indefinitely.

## Test plan
- HALT, slave acks next cycle → one write, addr 0, data 0x400; o_rsp_stb in cycle 3; err=0.
- RD_REG reg=5, slave returns 0xDEADBEEF → write 0x405 to addr 0, one cyc-low GAP cycle, read addr 1; o_rsp_data=0xDEADBEEF in cycle 6; stale GAP ack causes no extra phase.
- WR_REG reg=31, data 0x12345678, stall held 3 cycles in data phase → stb held through stall; data write completes; response in cycle 9.
- i_cmd_stb asserted every cycle during RD_CTRL → exactly one bus transaction and one response.
- i_rst asserted in D_WAIT → next cycle cyc=0, busy=0; no o_rsp_stb.
- ZIPDBG_TIMEOUT_EN with TIMEOUT=8, slave never acks → cyc drops after 8 cycles; o_rsp_stb with o_rsp_err=1 and o_rsp_data=0.

Source files
------------

// File: rtl/zipdbg_master.sv
// zipdbg_master: command/response initiator for the ZipCPU two-address debug Wishbone port.
// Define ZIPDBG_TIMEOUT_EN to compile in the per-phase ack timeout (parameter TIMEOUT).
module zipdbg_master
`ifdef ZIPDBG_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 1023
)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_stb,
  input  logic [2:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_reg,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_busy,
  output logic        o_rsp_stb,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_dbg_cyc,
  output logic        o_dbg_stb,
  output logic        o_dbg_we,
  output logic        o_dbg_addr,
  output logic [31:0] o_dbg_data,
  input  logic        i_dbg_ack,
  input  logic        i_dbg_stall,
  input  logic [31:0] i_dbg_data
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] OP_RD_CTRL = 3'd0;
  localparam logic [2:0] OP_WR_CTRL = 3'd1;
  localparam logic [2:0] OP_RD_REG  = 3'd2;
  localparam logic [2:0] OP_WR_REG  = 3'd3;
  localparam logic [2:0] OP_HALT    = 3'd4;
  localparam logic [2:0] OP_GO      = 3'd5;
  localparam logic [2:0] OP_STEP    = 3'd6;
  localparam logic [2:0] OP_RESET   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    C_STB,
    C_WAIT,
    GAP,
    D_STB,
    D_WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [2:0]    op;
  logic [DW-1:0] wdata;

  // Control word sent in the first (address 0) phase of every command.
  function automatic logic [DW-1:0] ctrl_word(input logic [2:0]    cop,
                                              input logic [4:0]    creg,
                                              input logic [DW-1:0] cdata);
    case (cop)
      OP_WR_CTRL:           return cdata;
      OP_RD_REG, OP_WR_REG: return DW'(32'h400) | DW'(creg);
      OP_HALT:              return DW'(32'h400);
      OP_GO:                return '0;
      OP_STEP:              return DW'(32'h100);
      OP_RESET:             return DW'(32'h440);
      default:              return '0;
    endcase
  endfunction

`ifdef ZIPDBG_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo_c;

  // Per-phase cycle counter; idles at zero outside the bus phases so each *_STB entry starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst || !(state inside {C_STB, C_WAIT, D_STB, D_WAIT}))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign tmo_c = (tmo_cnt >= CW'(TIMEOUT - 1));
`else
  logic tmo_c;
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      op         <= OP_RD_CTRL;
      wdata      <= '0;
      o_cmd_busy <= 1'b0;
      o_rsp_stb  <= 1'b0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
      o_dbg_cyc  <= 1'b0;
      o_dbg_stb  <= 1'b0;
      o_dbg_we   <= 1'b0;
      o_dbg_addr <= 1'b0;
      o_dbg_data <= '0;
    end else begin
      o_rsp_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_stb) begin
            op         <= i_cmd_op;
            wdata      <= i_cmd_data;
            o_cmd_busy <= 1'b1;
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b0;
            o_dbg_cyc  <= 1'b1;
            o_dbg_stb  <= 1'b1;
            o_dbg_addr <= 1'b0;
            o_dbg_we   <= (i_cmd_op != OP_RD_CTRL);
            o_dbg_data <= ctrl_word(i_cmd_op, i_cmd_reg, i_cmd_data);
            state      <= C_STB;
          end
        end

        C_STB, D_STB: begin
          if (tmo_c) begin
            o_dbg_cyc  <= 1'b0;
            o_dbg_stb  <= 1'b0;
            o_rsp_err  <= 1'b1;
            o_rsp_data <= '0;
            o_rsp_stb  <= 1'b1;
            state      <= RESP;
          end else if (!i_dbg_stall) begin
            o_dbg_stb <= 1'b0;
            state     <= (state == C_STB) ? C_WAIT : D_WAIT;
          end
        end

        C_WAIT: begin
          if (tmo_c) begin
            o_dbg_cyc  <= 1'b0;
            o_rsp_err  <= 1'b1;
            o_rsp_data <= '0;
            o_rsp_stb  <= 1'b1;
            state      <= RESP;
          end else if (i_dbg_ack) begin
            o_dbg_cyc <= 1'b0;
            if (op == OP_RD_REG || op == OP_WR_REG) begin
              state <= GAP;
            end else begin
              if (op == OP_RD_CTRL)
                o_rsp_data <= i_dbg_data;
              o_rsp_stb <= 1'b1;
              state     <= RESP;
            end
          end
        end

        // One cyc-low cycle swallows the slave's trailing ack from the control phase.
        GAP: begin
          o_dbg_cyc  <= 1'b1;
          o_dbg_stb  <= 1'b1;
          o_dbg_addr <= 1'b1;
          o_dbg_we   <= (op == OP_WR_REG);
          o_dbg_data <= (op == OP_WR_REG) ? wdata : '0;
          state      <= D_STB;
        end

        D_WAIT: begin
          if (tmo_c) begin
            o_dbg_cyc  <= 1'b0;
            o_rsp_err  <= 1'b1;
            o_rsp_data <= '0;
            o_rsp_stb  <= 1'b1;
            state      <= RESP;
          end else if (i_dbg_ack) begin
            o_dbg_cyc <= 1'b0;
            if (op == OP_RD_REG)
              o_rsp_data <= i_dbg_data;
            o_rsp_stb <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          o_cmd_busy <= 1'b0;
          o_dbg_we   <= 1'b0;
          o_dbg_addr <= 1'b0;
          o_dbg_data <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
